// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, bus widths and slave decode base.
package bus_pkg;

    localparam int BUS_AW  = 16;
    localparam int BUS_MDW = 32;

    localparam logic [7:0] BUS_SLV_BASE = 8'h01;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage : bus_pkg

// File: rtl/arb_mux2.sv
// Owner mux: passes the granted master's wr/addr/dout to the bus, zeros when nobody owns it.
module arb_mux2
    import bus_pkg::*;
(
    input  logic               i_sel0,
    input  logic               i_sel1,
    input  logic               i_wr0,
    input  logic               i_wr1,
    input  logic [BUS_AW-1:0]  i_addr0,
    input  logic [BUS_AW-1:0]  i_addr1,
    input  logic [BUS_MDW-1:0] i_dout0,
    input  logic [BUS_MDW-1:0] i_dout1,
    output logic               o_wr,
    output logic [BUS_AW-1:0]  o_addr,
    output logic [BUS_MDW-1:0] o_dout
);

    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        o_wr   = 1'b0;
        o_addr = '0;
        o_dout = '0;
        if (i_sel0) begin
            o_wr   = i_wr0;
            o_addr = i_addr0;
            o_dout = i_dout0;
        end else if (i_sel1) begin
            o_wr   = i_wr1;
            o_addr = i_addr1;
            o_dout = i_dout1;
        end
    end

endmodule : arb_mux2

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter with a hold limit, driving the single-master bus from the owner.
module bus_arbiter2
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               m0_req,
    input  logic               m1_req,
    input  logic               m0_wr,
    input  logic               m1_wr,
    input  logic [BUS_AW-1:0]  m0_addr,
    input  logic [BUS_AW-1:0]  m1_addr,
    input  logic [BUS_MDW-1:0] m0_dout,
    input  logic [BUS_MDW-1:0] m1_dout,
    output logic               m0_grant,
    output logic               m1_grant,
    output logic               b_req,
    output logic               b_wr,
    output logic [BUS_AW-1:0]  b_addr,
    output logic [BUS_MDW-1:0] b_dout,
    output logic [7:0]         hold_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last;
    logic [7:0] r_hold_cnt;
    logic       w_at_limit;

    // A waiter that arrives after the limit was passed still preempts on the next edge.
    assign w_at_limit = (r_hold_cnt >= HOLD_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (m0_req && m1_req) begin
                    w_next = r_last ? ARB_OWN0 : ARB_OWN1;
                end else if (m0_req) begin
                    w_next = ARB_OWN0;
                end else if (m1_req) begin
                    w_next = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                if (!m0_req) begin
                    w_next = m1_req ? ARB_OWN1 : ARB_IDLE;
                end else if (m1_req && w_at_limit) begin
                    w_next = ARB_OWN1;
                end
            end
            ARB_OWN1: begin
                if (!m1_req) begin
                    w_next = m0_req ? ARB_OWN0 : ARB_IDLE;
                end else if (m0_req && w_at_limit) begin
                    w_next = ARB_OWN0;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            r_state    <= ARB_IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next == ARB_OWN0) begin
                r_last <= 1'b0;
            end else if (w_next == ARB_OWN1) begin
                r_last <= 1'b1;
            end
            if ((w_next != r_state) || (r_state == ARB_IDLE)) begin
                r_hold_cnt <= 8'd0;
            end else if (r_hold_cnt != 8'hFF) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign m0_grant = (r_state == ARB_OWN0);
    assign m1_grant = (r_state == ARB_OWN1);
    assign b_req    = m0_grant | m1_grant;
    assign hold_cnt = r_hold_cnt;

    arb_mux2 u_mux (
        .i_sel0  (m0_grant),
        .i_sel1  (m1_grant),
        .i_wr0   (m0_wr),
        .i_wr1   (m1_wr),
        .i_addr0 (m0_addr),
        .i_addr1 (m1_addr),
        .i_dout0 (m0_dout),
        .i_dout1 (m1_dout),
        .o_wr    (b_wr),
        .o_addr  (b_addr),
        .o_dout  (b_dout)
    );

endmodule : bus_arbiter2
